video_timing_gen: RTL



---
 rtl/video_timing_pkg.sv | 45 ++++
 rtl/rise_edge_detect.sv | 32 +++
 rtl/video_timing_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module   : video_timing_pkg
// Purpose  : Standard raster timing sets and a line/frame total helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_ACTIVE  = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam bit          VGA_HSYNC_POL = 1'b0;
  localparam bit          VGA_VSYNC_POL = 1'b0;

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock
  localparam int unsigned HD720_H_ACTIVE  = 1280;
  localparam int unsigned HD720_H_FP      = 110;
  localparam int unsigned HD720_H_SYNC    = 40;
  localparam int unsigned HD720_H_BP      = 220;
  localparam int unsigned HD720_V_ACTIVE  = 720;
  localparam int unsigned HD720_V_FP      = 5;
  localparam int unsigned HD720_V_SYNC    = 5;
  localparam int unsigned HD720_V_BP      = 20;
  localparam bit          HD720_HSYNC_POL = 1'b1;
  localparam bit          HD720_VSYNC_POL = 1'b1;

  function automatic int unsigned calc_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_edge_detect.sv
// ============================================================================
// Module   : rise_edge_detect
// Purpose  : Single-cycle pulse on each low-to-high transition of a level.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rise_edge_detect #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_q;

  // Resetting to 1 suppresses a spurious edge when the level is already high at release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sig_q <= RST_VAL;
    end else begin
      sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~sig_q;

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing generator (syncs, DE, coordinates) for HDMI output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter bit          HSYNC_POL = VGA_HSYNC_POL,
  parameter bit          VSYNC_POL = VGA_VSYNC_POL,
  parameter int unsigned CNT_W     = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_clk,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_line_start,
  output logic             o_frame_start
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Region bounds carry one extra bit: a window may end exactly at 2^CNT_W.
  localparam logic [CNT_W:0] H_DE_END = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SY_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SY_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_DE_END = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SY_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SY_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] h_cnt_d;
  logic [CNT_W-1:0] v_cnt_d;
  logic             h_wrap;
  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;

  rise_edge_detect #(
    .RST_VAL (1'b1)
  ) u_pix_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_pix_clk),
    .o_rise (tick)
  );

  always_comb begin
    h_wrap  = (o_h_cnt == H_LAST);
    h_cnt_d = o_h_cnt;
    v_cnt_d = o_v_cnt;
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : o_h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt_d = (o_v_cnt == V_LAST) ? '0 : o_v_cnt + 1'b1;
      end
    end
    h_ext = {1'b0, h_cnt_d};
    v_ext = {1'b0, v_cnt_d};
  end

  // Everything decodes from the next position, so all outputs move together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_h_cnt       <= H_LAST;
      o_v_cnt       <= V_LAST;
      o_tick        <= 1'b0;
      o_de          <= 1'b0;
      o_hsync       <= ~HSYNC_POL;
      o_vsync       <= ~VSYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_h_cnt       <= h_cnt_d;
      o_v_cnt       <= v_cnt_d;
      o_tick        <= tick;
      o_de          <= (h_ext < H_DE_END) && (v_ext < V_DE_END);
      o_hsync       <= ((h_ext >= H_SY_BEG) && (h_ext < H_SY_END)) ? HSYNC_POL : ~HSYNC_POL;
      o_vsync       <= ((v_ext >= V_SY_BEG) && (v_ext < V_SY_END)) ? VSYNC_POL : ~VSYNC_POL;
      o_line_start  <= tick && (h_cnt_d == '0);
      o_frame_start <= tick && (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

endmodule

`default_nettype wire
